// File: rtl/buf_manager.sv
// Wishbone-slave buffer allocator: round-robin allocation on a read of register 0,
// release on a write of register 0, with status registers for free count and bitmap.
module buf_manager #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BUFS   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] wbs_address,
    input  logic [DATA_WIDTH-1:0] wbs_writedata,
    output logic [DATA_WIDTH-1:0] wbs_readdata,
    input  logic                  wbs_strobe,
    input  logic                  wbs_cycle,
    input  logic                  wbs_write,
    output logic                  wbs_ack,
    output logic [DATA_WIDTH-1:0] free_count,
    output logic                  alloc_fail,
    output logic                  release_err
);
    localparam int PTR_W = $clog2(NUM_BUFS);

    typedef enum logic {IDLE, ACK} state_t;

    state_t                state_q, state_d;
    logic [NUM_BUFS-1:0]   bitmap_q, bitmap_d;
    logic [PTR_W-1:0]      next_ptr_q, next_ptr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] free_q, free_d;
    logic                  ack_q, ack_d;
    logic                  afail_q, afail_d;
    logic                  rerr_q, rerr_d;

    logic                  found;
    logic [PTR_W-1:0]      free_idx;
    int                    scan_idx;
    logic [PTR_W-1:0]      rel_idx;
    logic                  rel_in_range;
    logic                  unused_addr;

    function automatic logic [DATA_WIDTH-1:0] free_of(input logic [NUM_BUFS-1:0] bm);
        int n;
        n = NUM_BUFS;
        for (int i = 0; i < NUM_BUFS; i++) begin
            if (bm[i]) n = n - 1;
        end
        return DATA_WIDTH'(n);
    endfunction

    assign unused_addr  = ^{wbs_address[ADDR_WIDTH-1:4], wbs_address[1:0]};
    assign rel_idx      = wbs_writedata[PTR_W-1:0];
    assign rel_in_range = (wbs_writedata < DATA_WIDTH'(NUM_BUFS));

    // Round-robin search: first free index at or after next_ptr, wrapping.
    always_comb begin
        found    = 1'b0;
        free_idx = '0;
        scan_idx = 0;
        for (int k = 0; k < NUM_BUFS; k++) begin
            scan_idx = int'(next_ptr_q) + k;
            if (scan_idx >= NUM_BUFS) scan_idx = scan_idx - NUM_BUFS;
            if (!found && !bitmap_q[PTR_W'(scan_idx)]) begin
                found    = 1'b1;
                free_idx = PTR_W'(scan_idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        bitmap_d   = bitmap_q;
        next_ptr_d = next_ptr_q;
        rdata_d    = '0;
        ack_d      = 1'b0;
        afail_d    = 1'b0;
        rerr_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (wbs_cycle && wbs_strobe) begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                    case (wbs_address[3:2])
                        2'd0: begin
                            if (wbs_write) begin
                                if (rel_in_range && bitmap_q[rel_idx]) bitmap_d[rel_idx] = 1'b0;
                                else                                   rerr_d = 1'b1;
                            end else if (found) begin
                                bitmap_d[free_idx] = 1'b1;
                                next_ptr_d = (free_idx == PTR_W'(NUM_BUFS - 1)) ? '0
                                                                                : free_idx + PTR_W'(1);
                                rdata_d    = DATA_WIDTH'(free_idx);
                            end else begin
                                rdata_d = '1;
                                afail_d = 1'b1;
                            end
                        end
                        2'd1:    if (!wbs_write) rdata_d = free_q;
                        2'd2:    if (!wbs_write) rdata_d = DATA_WIDTH'(bitmap_q);
                        default: ;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
        free_d = free_of(bitmap_d);
    end

    // Bitmap, pointer and free count all move on the edge that enters ACK.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bitmap_q   <= '0;
            next_ptr_q <= '0;
            rdata_q    <= '0;
            free_q     <= DATA_WIDTH'(NUM_BUFS);
            ack_q      <= 1'b0;
            afail_q    <= 1'b0;
            rerr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitmap_q   <= bitmap_d;
            next_ptr_q <= next_ptr_d;
            rdata_q    <= rdata_d;
            free_q     <= free_d;
            ack_q      <= ack_d;
            afail_q    <= afail_d;
            rerr_q     <= rerr_d;
        end
    end

    assign wbs_readdata = rdata_q;
    assign wbs_ack      = ack_q;
    assign free_count   = free_q;
    assign alloc_fail   = afail_q;
    assign release_err  = rerr_q;
endmodule

// File: tb/tb_buf_manager.sv
// Scoreboard bench for buf_manager: directed scenarios plus random traffic against
// a set-of-allocated-buffers reference model.
module tb_buf_manager;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] wbs_address = '0;
    logic [31:0] wbs_writedata = '0;
    logic [31:0] wbs_readdata;
    logic        wbs_strobe = 1'b0;
    logic        wbs_cycle = 1'b0;
    logic        wbs_write = 1'b0;
    logic        wbs_ack;
    logic [31:0] free_count;
    logic        alloc_fail;
    logic        release_err;

    buf_manager #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_BUFS(N)) dut (
        .clk(clk), .reset(reset),
        .wbs_address(wbs_address), .wbs_writedata(wbs_writedata),
        .wbs_readdata(wbs_readdata), .wbs_strobe(wbs_strobe),
        .wbs_cycle(wbs_cycle), .wbs_write(wbs_write), .wbs_ack(wbs_ack),
        .free_count(free_count), .alloc_fail(alloc_fail), .release_err(release_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        afail;
        logic        rerr;
        logic [31:0] free;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          vectors = 0;
    int          errors = 0;
    int          cyc_cnt = 0;
    logic [31:0] last_free = N;

    // Reference model: which buffers are held, and where the next search starts.
    bit alloc_m[N];
    int nptr_m;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc_cnt);
        end
    endtask

    function automatic int model_free();
        int n = N;
        for (int i = 0; i < N; i++) if (alloc_m[i]) n--;
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) alloc_m[i] = 1'b0;
        nptr_m = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // One bus transaction; the expected response is queued before the request is driven.
    task automatic issue(input logic [1:0] sel, input bit wr, input logic [31:0] data,
                         input bit hold, input bit rst_in_ack);
        exp_t        e;
        logic [31:0] a;
        bit          got;
        int          idx;
        e.rdata = '0;
        e.afail = 1'b0;
        e.rerr  = 1'b0;
        if (sel == 2'd0 && !wr) begin
            got = 1'b0;
            for (int k = 0; k < N; k++) begin
                idx = (nptr_m + k) % N;
                if (!got && !alloc_m[idx]) begin
                    got = 1'b1;
                    alloc_m[idx] = 1'b1;
                    e.rdata = idx;
                    nptr_m = (idx + 1) % N;
                end
            end
            if (!got) begin
                e.rdata = 32'hFFFF_FFFF;
                e.afail = 1'b1;
            end
        end else if (sel == 2'd0) begin
            if (data < 32'(N) && alloc_m[data]) alloc_m[data] = 1'b0;
            else e.rerr = 1'b1;
        end else if (sel == 2'd1 && !wr) begin
            e.rdata = model_free();
        end else if (sel == 2'd2 && !wr) begin
            for (int i = 0; i < N; i++) e.rdata[i] = alloc_m[i];
        end
        e.free = model_free();
        e.cyc  = cyc_cnt + 1;
        sb.push_back(e);

        a = $urandom();
        a[3:2] = sel;
        wbs_address   = a;
        wbs_writedata = data;
        wbs_write     = wr;
        wbs_cycle     = 1'b1;
        wbs_strobe    = 1'b1;
        step();
        if (rst_in_ack) begin
            reset = 1'b1;
            model_reset();
        end
        if (!hold) begin
            wbs_cycle  = 1'b0;
            wbs_strobe = 1'b0;
        end
        step();
        wbs_cycle  = 1'b0;
        wbs_strobe = 1'b0;
        if (rst_in_ack) begin
            step();
            reset = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (wbs_ack === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'(wbs_ack), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("ack_latency", 32'(cyc_cnt), 32'(mon_e.cyc));
                chk("readdata", wbs_readdata, mon_e.rdata);
                chk("alloc_fail", 32'(alloc_fail), 32'(mon_e.afail));
                chk("release_err", 32'(release_err), 32'(mon_e.rerr));
                chk("free_count", free_count, mon_e.free);
                last_free = mon_e.free;
            end
        end else begin
            if (reset) last_free = N;
            chk("idle_ack", 32'(wbs_ack), 32'd0);
            chk("idle_readdata", wbs_readdata, 32'd0);
            chk("idle_alloc_fail", 32'(alloc_fail), 32'd0);
            chk("idle_release_err", 32'(release_err), 32'd0);
            chk("idle_free_count", free_count, last_free);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  sel;
        int          r;
        logic [31:0] d;
        model_reset();
        repeat (3) step();
        reset = 1'b0;
        step();

        issue(2'd1, 1'b0, 32'd0, 1'b0, 1'b0);
        issue(2'd2, 1'b0, 32'd0, 1'b0, 1'b0);
        issue(2'd3, 1'b0, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) issue(2'd0, 1'b0, 32'd0, i[0], 1'b0);
        issue(2'd1, 1'b0, 32'd0, 1'b0, 1'b0);
        issue(2'd2, 1'b0, 32'd0, 1'b0, 1'b0);
        issue(2'd0, 1'b0, 32'd0, 1'b0, 1'b0);

        // Wrap-around: freed slot 1 comes back, then the search resumes at 2.
        issue(2'd0, 1'b1, 32'd1, 1'b0, 1'b0);
        issue(2'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        issue(2'd0, 1'b1, 32'd0, 1'b0, 1'b0);
        issue(2'd0, 1'b1, 32'd3, 1'b0, 1'b0);
        issue(2'd0, 1'b0, 32'd0, 1'b0, 1'b0);

        issue(2'd0, 1'b1, 32'd2, 1'b0, 1'b0);
        issue(2'd0, 1'b1, 32'd2, 1'b0, 1'b0);
        issue(2'd0, 1'b1, 32'd7, 1'b1, 1'b0);
        issue(2'd2, 1'b0, 32'd0, 1'b0, 1'b0);
        issue(2'd1, 1'b0, 32'd0, 1'b0, 1'b0);

        // Strobe without cycle must be ignored.
        wbs_address = '0;
        wbs_write   = 1'b0;
        wbs_strobe  = 1'b1;
        wbs_cycle   = 1'b0;
        repeat (5) step();
        wbs_strobe = 1'b0;
        issue(2'd1, 1'b0, 32'd0, 1'b0, 1'b0);
        issue(2'd0, 1'b0, 32'd0, 1'b0, 1'b0);

        issue(2'd1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        issue(2'd2, 1'b1, 32'h0000_0000, 1'b0, 1'b0);
        issue(2'd3, 1'b1, 32'h0000_0005, 1'b0, 1'b0);
        issue(2'd2, 1'b0, 32'd0, 1'b0, 1'b0);

        for (int t = 0; t < 300; t++) begin
            r   = $urandom_range(0, 9);
            sel = (r < 6) ? 2'd0 : 2'(r - 6);
            d   = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, N + 1));
            issue(sel, 1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)), 1'b0);
            repeat ($urandom_range(0, 2)) step();
        end

        // Reset landing in the ACK cycle of an allocation.
        issue(2'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        issue(2'd2, 1'b0, 32'd0, 1'b0, 1'b0);
        issue(2'd1, 1'b0, 32'd0, 1'b0, 1'b0);
        issue(2'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        issue(2'd2, 1'b0, 32'd0, 1'b0, 1'b0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        chk("missing_ack", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/buf_manager.md
BUF_MANAGER -- requirements
Module: buf_manager

Interface
REQ-001 The block SHALL have one clock `clk`, and reset SHALL be synchronous and active-high on `reset`.
REQ-002 Parameters (name, default, meaning):
- ADDR_WIDTH, 32, Wishbone address width.
- DATA_WIDTH, 32, Wishbone data width.
- NUM_BUFS, 4, number of managed buffers; legal range 2..16.
REQ-003 Ports (name  direction  width  meaning):
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- wbs_address  in  ADDR_WIDTH  slave address; only bits [3:2] are decoded.
- wbs_writedata  in  DATA_WIDTH  write data.
- wbs_readdata  out  DATA_WIDTH  read data.
- wbs_strobe  in  1  Wishbone STB.
- wbs_cycle  in  1  Wishbone CYC.
- wbs_write  in  1  1 = write, 0 = read.
- wbs_ack  out  1  Wishbone ACK.
- free_count  out  DATA_WIDTH  number of currently free buffers.
- alloc_fail  out  1  one-cycle pulse: allocation requested while no buffer was free.
- release_err  out  1  one-cycle pulse: illegal release.

Function
REQ-004 Register map (wbs_address[3:2]):
- 0 = ALLOC/RELEASE: read allocates, write releases.
- 1 = FREE_COUNT: read-only.
- 2 = BITMAP: read-only; bit i = 1 means buffer i is allocated.
- 3 = reserved: reads return 0.
REQ-005 State machine: two states, IDLE and ACK.
- IDLE -> ACK when wbs_cycle & wbs_strobe is sampled high at a clock edge.
- ACK -> IDLE unconditionally.
REQ-006 Handshake:
- wbs_ack SHALL be registered, high exactly in the ACK state, and low otherwise.
- Latency from the request edge to ack SHALL be 1 cycle.
- A new request SHALL NOT be sampled while in ACK.
REQ-007 wbs_strobe high with wbs_cycle low SHALL be ignored: no ack and no state change.
REQ-008 wbs_readdata SHALL be registered, valid only while wbs_ack = 1, and 0 in all other cycles.
REQ-009 Allocation (read of register 0):
- Search the allocation bitmap round-robin for the first free index, starting at next_ptr and wrapping modulo NUM_BUFS.
- On success, set that bit, return the index zero-extended to DATA_WIDTH, and set next_ptr to (index + 1) mod NUM_BUFS.
REQ-010 Allocation with no free buffer SHALL:
- return all-ones;
- pulse alloc_fail in the ACK cycle;
- leave the bitmap and next_ptr unchanged.
REQ-011 Release (write to register 0) with id = wbs_writedata SHALL clear bitmap bit id when id < NUM_BUFS and that bit is set; next_ptr SHALL be unchanged.
REQ-012 Release with id >= NUM_BUFS, or of a buffer that is already free, SHALL leave state unchanged and pulse release_err in the ACK cycle.
REQ-013 The following SHALL be acked with no side effects:
- writes to registers 1-3;
- reads of registers 1-3, which SHALL also not change next_ptr.
REQ-014 free_count:
- SHALL equal NUM_BUFS minus the population count of the bitmap.
- SHALL be registered and update in the ACK cycle of the modifying transaction.
- SHALL never go below 0 or above NUM_BUFS.
REQ-015 Bitmap and next_ptr updates SHALL take effect at the edge that enters ACK, so that a following transaction sees the updated state.
REQ-016 alloc_fail and release_err SHALL each be high for exactly one cycle, coincident with wbs_ack.

Reset
REQ-017 While reset is sampled high, the block SHALL force:
- state = IDLE;
- wbs_ack = 0, wbs_readdata = 0;
- bitmap = 0 (all buffers free), next_ptr = 0;
- free_count = NUM_BUFS;
- alloc_fail = 0, release_err = 0.
REQ-018 Reset asserted during the ACK state SHALL drop wbs_ack at the next edge, and the aborted transaction's bitmap change SHALL be discarded.

Verification
REQ-019 After reset with NUM_BUFS=4, four register-0 reads SHALL:
- return 0, 1, 2, 3, each with ack exactly 1 cycle after the request edge;
- leave free_count = 0 and BITMAP = 0xF.
REQ-020 A fifth register-0 read SHALL:
- return 0xFFFFFFFF;
- pulse alloc_fail for 1 cycle;
- leave free_count = 0.
REQ-021 Wrap-around: starting with buffers 0..3 allocated, release 1, then read register 0 -> the read SHALL return 1, and next_ptr SHALL wrap to 2.
REQ-022 Illegal releases SHALL each be acked with release_err pulsed and no change to BITMAP or free_count:
- writing 2 twice, where the second write is a double release;
- writing 7, which is out of range.
REQ-023 stb = 1 with cyc = 0 for 5 cycles -> no ack and no state change; register 1 read -> returns free_count, and next_ptr SHALL be unchanged.
REQ-024 Reset asserted in the ACK cycle of an allocation -> ack = 0 on the next cycle, BITMAP = 0, free_count = 4, and the next allocation SHALL return 0.
